// File: rtl/bus_sampler_pkg.sv
// Shared definitions for the C64 bus logic-analyser capture path.
package bus_sampler_pkg;

    localparam int SAMPLE_DEPTH_LOG2 = 10;
    localparam int C64_ADDR_W        = 16;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_WAIT = 3'd2,
        ST_POST = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    // Sample word layout, shared with the sample buffer writer.
    localparam int SW_ADDR_LSB = 0;
    localparam int SW_RW_BIT   = 16;
    localparam int SW_IRQ_BIT  = 17;
    localparam int SW_NMI_BIT  = 18;
    localparam int SW_EXT_BIT  = 19;
    localparam int SW_WIDTH    = 20;

endpackage

// File: rtl/bus_sampler_trig.sv
// Sample strobe generation and combinational trigger match.
module bus_sampler_trig
    import bus_sampler_pkg::*;
#(
    parameter int ADDR_W = C64_ADDR_W
) (
    input  logic              clk_sys,
    input  logic              rst_n,
    input  logic              mode_phi2,
    input  logic [ADDR_W-1:0] trig_addr,
    input  logic [ADDR_W-1:0] trig_mask,
    input  logic              trig_addr_en,
    input  logic              trig_rw_en,
    input  logic              trig_rw_val,
    input  logic              trig_irq_en,
    input  logic              trig_nmi_en,
    input  logic              ext_trig_en,
    input  logic              ext_trig,
    input  logic [ADDR_W-1:0] c64_addr,
    input  logic              c64_rw,
    input  logic              c64_phi2,
    input  logic              c64_irq_n,
    input  logic              c64_nmi_n,
    output logic              strobe,
    output logic              match
);

    logic phi2_d;
    logic addr_hit;

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) phi2_d <= 1'b0;
        else        phi2_d <= c64_phi2;
    end

    // Fires on the first cycle PHI2 is seen low.
    assign strobe = mode_phi2 ? (phi2_d & ~c64_phi2) : 1'b1;

    assign addr_hit = trig_addr_en
                    && (((c64_addr ^ trig_addr) & trig_mask) == '0)
                    && (!trig_rw_en || (c64_rw == trig_rw_val));

    assign match = addr_hit
                 | (trig_irq_en & ~c64_irq_n)
                 | (trig_nmi_en & ~c64_nmi_n)
                 | (ext_trig_en & ext_trig);

endmodule

// File: rtl/bus_sampler_ctrl.sv
// Capture sequencer: pre-trigger fill, trigger wait, post-trigger fill, stop.
module bus_sampler_ctrl
    import bus_sampler_pkg::*;
#(
    parameter int DEPTH_LOG2 = SAMPLE_DEPTH_LOG2,
    parameter int ADDR_W     = C64_ADDR_W
) (
    input  logic                  clk_sys,
    input  logic                  rst_n,
    input  logic                  arm,
    input  logic                  abort,
    input  logic                  mode_phi2,
    input  logic [DEPTH_LOG2-1:0] pre_len,
    input  logic [DEPTH_LOG2-1:0] post_len,
    input  logic [ADDR_W-1:0]     trig_addr,
    input  logic [ADDR_W-1:0]     trig_mask,
    input  logic                  trig_addr_en,
    input  logic                  trig_rw_en,
    input  logic                  trig_rw_val,
    input  logic                  trig_irq_en,
    input  logic                  trig_nmi_en,
    input  logic                  ext_trig_en,
    input  logic                  ext_trig,
    input  logic [ADDR_W-1:0]     c64_addr,
    input  logic                  c64_rw,
    input  logic                  c64_phi2,
    input  logic                  c64_irq_n,
    input  logic                  c64_nmi_n,
    output logic                  sample_we,
    output logic [DEPTH_LOG2-1:0] sample_waddr,
    output logic [2:0]            state,
    output logic                  triggered,
    output logic                  done,
    output logic                  cfg_err,
    output logic [DEPTH_LOG2-1:0] trig_index,
    output logic [DEPTH_LOG2-1:0] start_index
);

    localparam logic [DEPTH_LOG2:0] DEPTH_N = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic                  mode_q, aen_q, rwen_q, rwval_q, irqen_q, nmien_q, exten_q;
    logic [DEPTH_LOG2-1:0] pre_q, post_q;
    logic [ADDR_W-1:0]     taddr_q, tmask_q;

    state_e                st, st_nxt;
    logic [DEPTH_LOG2-1:0] cnt, cnt_nxt, cnt_inc, waddr_nxt, ti_nxt, si_nxt;
    logic                  trig_nxt, done_nxt, err_nxt, cfg_ld;
    logic [DEPTH_LOG2:0]   need;
    logic                  strobe, match, busy;

    bus_sampler_trig #(.ADDR_W(ADDR_W)) u_trig (
        .clk_sys     (clk_sys),
        .rst_n       (rst_n),
        .mode_phi2   (mode_q),
        .trig_addr   (taddr_q),
        .trig_mask   (tmask_q),
        .trig_addr_en(aen_q),
        .trig_rw_en  (rwen_q),
        .trig_rw_val (rwval_q),
        .trig_irq_en (irqen_q),
        .trig_nmi_en (nmien_q),
        .ext_trig_en (exten_q),
        .ext_trig    (ext_trig),
        .c64_addr    (c64_addr),
        .c64_rw      (c64_rw),
        .c64_phi2    (c64_phi2),
        .c64_irq_n   (c64_irq_n),
        .c64_nmi_n   (c64_nmi_n),
        .strobe      (strobe),
        .match       (match)
    );

    assign need      = {1'b0, pre_len} + {1'b0, post_len} + {{DEPTH_LOG2{1'b0}}, 1'b1};
    assign busy      = (st == ST_PRE) || (st == ST_WAIT) || (st == ST_POST);
    assign sample_we = strobe & busy & ~abort;
    assign cnt_inc   = cnt + 1'b1;
    assign state     = st;

    always_comb begin
        st_nxt    = st;
        cnt_nxt   = cnt;
        waddr_nxt = sample_waddr;
        trig_nxt  = triggered;
        done_nxt  = done;
        err_nxt   = cfg_err;
        ti_nxt    = trig_index;
        si_nxt    = start_index;
        cfg_ld    = 1'b0;
        if (abort) begin
            st_nxt   = ST_IDLE;
            trig_nxt = 1'b0;
            done_nxt = 1'b0;
        end else begin
            case (st)
                ST_IDLE, ST_DONE: begin
                    if (arm) begin
                        if (need > DEPTH_N) begin
                            err_nxt = 1'b1;
                        end else begin
                            cfg_ld    = 1'b1;
                            err_nxt   = 1'b0;
                            trig_nxt  = 1'b0;
                            done_nxt  = 1'b0;
                            waddr_nxt = '0;
                            cnt_nxt   = '0;
                            st_nxt    = (pre_len != '0) ? ST_PRE : ST_WAIT;
                        end
                    end
                end
                ST_PRE: begin
                    if (sample_we) begin
                        waddr_nxt = sample_waddr + 1'b1;
                        cnt_nxt   = cnt_inc;
                        if (cnt_inc == pre_q) st_nxt = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (sample_we) begin
                        waddr_nxt = sample_waddr + 1'b1;
                        if (match) begin
                            ti_nxt   = sample_waddr;
                            si_nxt   = sample_waddr - pre_q;
                            trig_nxt = 1'b1;
                            cnt_nxt  = '0;
                            if (post_q == '0) begin
                                st_nxt   = ST_DONE;
                                done_nxt = 1'b1;
                            end else begin
                                st_nxt = ST_POST;
                            end
                        end
                    end
                end
                ST_POST: begin
                    if (sample_we) begin
                        waddr_nxt = sample_waddr + 1'b1;
                        cnt_nxt   = cnt_inc;
                        if (cnt_inc == post_q) begin
                            st_nxt   = ST_DONE;
                            done_nxt = 1'b1;
                        end
                    end
                end
                default: st_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            st           <= ST_IDLE;
            cnt          <= '0;
            sample_waddr <= '0;
            triggered    <= 1'b0;
            done         <= 1'b0;
            cfg_err      <= 1'b0;
            trig_index   <= '0;
            start_index  <= '0;
        end else begin
            st           <= st_nxt;
            cnt          <= cnt_nxt;
            sample_waddr <= waddr_nxt;
            triggered    <= trig_nxt;
            done         <= done_nxt;
            cfg_err      <= err_nxt;
            trig_index   <= ti_nxt;
            start_index  <= si_nxt;
        end
    end

    // Capture config is frozen at arm so register writes mid-capture are harmless.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            mode_q  <= 1'b0;
            pre_q   <= '0;
            post_q  <= '0;
            taddr_q <= '0;
            tmask_q <= '0;
            aen_q   <= 1'b0;
            rwen_q  <= 1'b0;
            rwval_q <= 1'b0;
            irqen_q <= 1'b0;
            nmien_q <= 1'b0;
            exten_q <= 1'b0;
        end else if (cfg_ld) begin
            mode_q  <= mode_phi2;
            pre_q   <= pre_len;
            post_q  <= post_len;
            taddr_q <= trig_addr;
            tmask_q <= trig_mask;
            aen_q   <= trig_addr_en;
            rwen_q  <= trig_rw_en;
            rwval_q <= trig_rw_val;
            irqen_q <= trig_irq_en;
            nmien_q <= trig_nmi_en;
            exten_q <= ext_trig_en;
        end
    end

endmodule
